// File: rtl/joy_pkg.sv
// Shared encodings and helpers for the joystick direction conditioner.
// Direction nibbles are active-high: bit0 right, bit1 left, bit2 down, bit3 up.
package joy_pkg;

    typedef logic [3:0] dir_t;

    localparam logic [1:0] JM_8WAY    = 2'd0;
    localparam logic [1:0] JM_4LAST   = 2'd1;
    localparam logic [1:0] JM_4FIRST  = 2'd2;
    localparam logic [1:0] JM_4LEGACY = 2'd3;

    localparam logic [1:0] JR_0   = 2'd0;
    localparam logic [1:0] JR_90  = 2'd1;
    localparam logic [1:0] JR_180 = 2'd2;
    localparam logic [1:0] JR_270 = 2'd3;

    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;

    // Highest-index set bit as a one-hot nibble; up beats down beats left beats right.
    function automatic dir_t hi_onehot(input dir_t v);
        dir_t r;
        r = 4'b0000;
        if (v[JB_UP]) begin
            r = 4'b1000;
        end else if (v[JB_DOWN]) begin
            r = 4'b0100;
        end else if (v[JB_LEFT]) begin
            r = 4'b0010;
        end else if (v[JB_RIGHT]) begin
            r = 4'b0001;
        end else begin
            r = 4'b0000;
        end
        return r;
    endfunction

    // Rotate a raw nibble to screen orientation; each output bit takes one input bit.
    function automatic dir_t rotate_dir(input dir_t d, input logic [1:0] r);
        dir_t o;
        o = d;
        case (r)
            JR_0:    o = d;
            JR_90:   o = {d[JB_LEFT],  d[JB_RIGHT], d[JB_DOWN],  d[JB_UP]};
            JR_180:  o = {d[JB_DOWN],  d[JB_UP],    d[JB_RIGHT], d[JB_LEFT]};
            JR_270:  o = {d[JB_RIGHT], d[JB_LEFT],  d[JB_UP],    d[JB_DOWN]};
            default: o = 4'b0000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/joy_dir_lane.sv
// One player's lane: input register, per-bit debounce, direction arbiter,
// registered dir_out and a change pulse derived from the registered output.
module joy_dir_lane
    import joy_pkg::*;
#(
    parameter int DB_TICKS = 0
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       srst,
    input  logic       ce_db,
    input  logic [1:0] mode,
    input  logic [3:0] dir_rot,
    output logic [3:0] dir_out,
    output logic       dir_chg
);

    logic [3:0] s1_r;
    logic [3:0] stable_s;
    logic [3:0] stable_prev_r;
    logic [3:0] mask_r;
    logic [3:0] mask_next_s;
    logic [3:0] out_next_s;
    logic [3:0] new_s;
    logic [3:0] held_s;
    logic [3:0] socd_s;
    logic [3:0] dir_out_r;
    logic [3:0] dir_out_d_r;
    logic       dir_chg_r;
    logic       ud_both_s;
    logic       lr_both_s;

    generate
        if (DB_TICKS == 0) begin : g_nodb
            logic ce_unused_s;
            assign ce_unused_s = ce_db;
            assign stable_s    = s1_r;
        end else begin : g_db
            localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
            localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

            logic [3:0]    stable_r;
            logic [CW-1:0] cnt_r [4];

            // Per-bit debounce: a bit flips only after DB_TICKS consecutive disagreeing ticks.
            always_ff @(posedge clk_sys) begin
                if (!reset_n || srst) begin
                    stable_r <= 4'b0000;
                    for (int b = 0; b < 4; b++) begin
                        cnt_r[b] <= {CW{1'b0}};
                    end
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (s1_r[b] == stable_r[b]) begin
                            cnt_r[b] <= {CW{1'b0}};
                        end else if (ce_db) begin
                            if (cnt_r[b] == CNT_LAST) begin
                                stable_r[b] <= ~stable_r[b];
                                cnt_r[b]    <= {CW{1'b0}};
                            end else begin
                                cnt_r[b] <= cnt_r[b] + CW'(1);
                            end
                        end
                    end
                end
            end

            assign stable_s = stable_r;
        end
    endgenerate

    assign ud_both_s = stable_s[JB_UP] & stable_s[JB_DOWN];
    assign lr_both_s = stable_s[JB_LEFT] & stable_s[JB_RIGHT];
    assign socd_s    = {stable_s[JB_UP]   & ~ud_both_s,
                        stable_s[JB_DOWN] & ~ud_both_s,
                        stable_s[JB_LEFT] & ~lr_both_s,
                        stable_s[JB_RIGHT] & ~lr_both_s};

    // Arbiter: next mask per mode; 4-way modes pass only the masked direction.
    always_comb begin
        new_s       = stable_s & ~stable_prev_r;
        held_s      = mask_r & stable_s;
        mask_next_s = mask_r;
        out_next_s  = 4'b0000;
        case (mode)
            JM_8WAY: begin
                mask_next_s = mask_r;
                out_next_s  = socd_s;
            end
            JM_4LAST: begin
                // A fresh press always beats fallback to a still-held direction.
                if (new_s != 4'b0000) begin
                    mask_next_s = hi_onehot(new_s);
                end else if ((held_s == 4'b0000) && (stable_s != 4'b0000)) begin
                    mask_next_s = hi_onehot(stable_s);
                end else if (stable_s == 4'b0000) begin
                    mask_next_s = 4'b0000;
                end else begin
                    mask_next_s = mask_r;
                end
                out_next_s = stable_s & mask_next_s;
            end
            JM_4FIRST: begin
                if (held_s == 4'b0000) begin
                    mask_next_s = hi_onehot(stable_s);
                end else begin
                    mask_next_s = mask_r;
                end
                out_next_s = stable_s & mask_next_s;
            end
            JM_4LEGACY: begin
                if (new_s != 4'b0000) begin
                    mask_next_s = hi_onehot(new_s);
                end else begin
                    mask_next_s = mask_r;
                end
                out_next_s = stable_s & mask_next_s;
            end
            default: begin
                mask_next_s = 4'b0000;
                out_next_s  = 4'b0000;
            end
        endcase
    end

    // Pipeline registers; the change pulse compares dir_out against its previous value.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            s1_r          <= 4'b0000;
            stable_prev_r <= 4'b0000;
            mask_r        <= 4'b0000;
            dir_out_r     <= 4'b0000;
            dir_out_d_r   <= 4'b0000;
            dir_chg_r     <= 1'b0;
        end else begin
            s1_r        <= dir_rot;
            dir_out_d_r <= dir_out_r;
            dir_chg_r   <= (dir_out_r != dir_out_d_r);
            if (srst) begin
                stable_prev_r <= 4'b0000;
                mask_r        <= 4'b0000;
                dir_out_r     <= 4'b0000;
            end else begin
                stable_prev_r <= stable_s;
                mask_r        <= mask_next_s;
                dir_out_r     <= out_next_s;
            end
        end
    end

    assign dir_out = dir_out_r;
    assign dir_chg = dir_chg_r;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner: rotation, mode/rot change
// detection (soft-resets every lane) and one joy_dir_lane per player.
module joy_dir_filter
    import joy_pkg::*;
#(
    parameter int PLAYERS  = 2,
    parameter int DB_TICKS = 0
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_db,
    input  logic [1:0]             mode,
    input  logic [1:0]             rot,
    input  logic [4*PLAYERS-1:0]   dir_in,
    output logic [4*PLAYERS-1:0]   dir_out,
    output logic [PLAYERS-1:0]     dir_chg
);

    logic [1:0]           mode_prev_r;
    logic [1:0]           rot_prev_r;
    logic                 cfg_chg_s;
    logic [4*PLAYERS-1:0] dir_rot_s;

    // Previous-cycle mode/rot; loaded during reset so release is not seen as a change.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mode_prev_r <= mode;
            rot_prev_r  <= rot;
        end else begin
            mode_prev_r <= mode;
            rot_prev_r  <= rot;
        end
    end

    assign cfg_chg_s = (mode != mode_prev_r) || (rot != rot_prev_r);

    // Rotation mux applied to every lane's raw nibble.
    always_comb begin
        dir_rot_s = {(4*PLAYERS){1'b0}};
        for (int p = 0; p < PLAYERS; p++) begin
            dir_rot_s[4*p +: 4] = rotate_dir(dir_in[4*p +: 4], rot);
        end
    end

    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
            joy_dir_lane #(
                .DB_TICKS (DB_TICKS)
            ) u_lane (
                .clk_sys  (clk_sys),
                .reset_n  (reset_n),
                .srst     (cfg_chg_s),
                .ce_db    (ce_db),
                .mode     (mode),
                .dir_rot  (dir_rot_s[4*p +: 4]),
                .dir_out  (dir_out[4*p +: 4]),
                .dir_chg  (dir_chg[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Scoreboard bench: stimulus pushes each expected dir_out transition per lane,
// a negedge monitor pops one entry per dir_chg pulse and compares.
module tb_joy_dir_filter;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_db;
    logic [1:0] ce_cnt = 2'd0;
    logic [1:0] mode_a, rot_a, mode_b, rot_b;
    logic [7:0] din_a, dout_a, din_b, dout_b;
    logic [1:0] chg_a, chg_b;

    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    logic [3:0] q2 [$];
    logic [3:0] hist0 = 4'b0000;
    logic [3:0] hist1 = 4'b0000;
    logic [3:0] hist2 = 4'b0000;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    joy_dir_filter #(.PLAYERS(2), .DB_TICKS(0)) u_dut_a (
        .clk_sys (clk_sys), .reset_n (reset_n), .ce_db (ce_db),
        .mode (mode_a), .rot (rot_a), .dir_in (din_a),
        .dir_out (dout_a), .dir_chg (chg_a)
    );

    joy_dir_filter #(.PLAYERS(2), .DB_TICKS(3)) u_dut_b (
        .clk_sys (clk_sys), .reset_n (reset_n), .ce_db (ce_db),
        .mode (mode_b), .rot (rot_b), .dir_in (din_b),
        .dir_out (dout_b), .dir_chg (chg_b)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic pop_cmp(input int s, input logic [3:0] act);
        logic [3:0] e;
        bit         ok;
        e  = 4'b0000;
        ok = 1'b0;
        case (s)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL chg_unexpected stream%0d: dir_out %b, expected no transition", s, act);
        end else begin
            check($sformatf("chg_stream%0d", s), act, e);
        end
    endtask

    // Monitor: a pulse refers to the dir_out value that appeared one cycle earlier.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (chg_a[0]) pop_cmp(0, hist0);
            if (chg_a[1]) pop_cmp(1, hist1);
            if (chg_b[0]) pop_cmp(2, hist2);
        end
        hist0 = dout_a[3:0];
        hist1 = dout_a[7:4];
        hist2 = dout_b[3:0];
    end

    // Debounce tick: one clk in every four.
    initial begin
        ce_db = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_db  = (ce_cnt == 2'd3);
            ce_cnt = ce_cnt + 2'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mode_a  = 2'd1;
        rot_a   = 2'd0;
        din_a   = 8'hFF;
        mode_b  = 2'd1;
        rot_b   = 2'd0;
        din_b   = 8'h00;
        tick(3);
        check("rst_out_a0", dout_a[3:0], 4'b0000);
        check("rst_out_a1", dout_a[7:4], 4'b0000);
        check("rst_chg_a", {2'b00, chg_a}, 4'b0000);
        check("rst_out_b0", dout_b[3:0], 4'b0000);

        // Release with all directions held in mode 1: up wins.
        q0.push_back(4'b1000);
        q1.push_back(4'b1000);
        reset_n = 1'b1;
        tick(1);
        check("rel_edge0", dout_a[3:0], 4'b0000);
        tick(1);
        check("rel_edge1", dout_a[3:0], 4'b1000);
        din_a = 8'h00;
        q0.push_back(4'b0000);
        q1.push_back(4'b0000);
        tick(5);

        // Mode 1 fallback.
        din_a = 8'h01; q0.push_back(4'b0001); tick(5);
        din_a = 8'h09; q0.push_back(4'b1000); tick(5);
        din_a = 8'h01; q0.push_back(4'b0001);
        tick(1);
        check("m1_fb_hold", dout_a[3:0], 4'b1000);
        tick(1);
        check("m1_fb_lat", dout_a[3:0], 4'b0001);
        tick(4);
        din_a = 8'h00; q0.push_back(4'b0000); tick(5);

        // Mode 3 legacy: release of up leaves right masked off.
        mode_a = 2'd3; tick(3);
        din_a = 8'h01; q0.push_back(4'b0001); tick(5);
        din_a = 8'h09; q0.push_back(4'b1000); tick(5);
        din_a = 8'h01; q0.push_back(4'b0000); tick(5);
        check("m3_legacy", dout_a[3:0], 4'b0000);
        din_a = 8'h00; tick(5);

        // Mode 0 SOCD, lane 1 independent.
        mode_a = 2'd0;
        din_a  = {4'b1010, 4'b1101};
        q0.push_back(4'b0001);
        q1.push_back(4'b1010);
        tick(5);
        check("m0_socd_ud", dout_a[3:0], 4'b0001);
        din_a = {4'b1010, 4'b0011}; q0.push_back(4'b0000); tick(5);
        check("m0_socd_lr", dout_a[3:0], 4'b0000);
        din_a = 8'h00; q1.push_back(4'b0000); tick(5);

        // Mode 2 first-held.
        mode_a = 2'd2; tick(3);
        din_a = 8'h01; q0.push_back(4'b0001); tick(5);
        din_a = 8'h09; tick(5);
        check("m2_hold", dout_a[3:0], 4'b0001);
        din_a = 8'h08; q0.push_back(4'b1000); tick(5);
        din_a = 8'h00; q0.push_back(4'b0000); tick(5);

        // Mode 1: press and release on the same cycle, press wins.
        mode_a = 2'd1; tick(3);
        din_a = 8'h04; q0.push_back(4'b0100); tick(5);
        din_a = 8'h0C; q0.push_back(4'b1000); tick(5);
        din_a = 8'h05; q0.push_back(4'b0001); tick(5);
        din_a = 8'h00; q0.push_back(4'b0000); tick(5);

        // Rotation, including a change while held.
        rot_a = 2'd1; din_a = 8'h02; q0.push_back(4'b1000); tick(5);
        rot_a = 2'd3; din_a = 8'h01;
        q0.push_back(4'b0000);
        q0.push_back(4'b1000);
        tick(1);
        check("rot_clr", dout_a[3:0], 4'b0000);
        tick(1);
        check("rot_back", dout_a[3:0], 4'b1000);
        tick(4);
        din_a = 8'h00; q0.push_back(4'b0000); tick(5);
        rot_a = 2'd2; tick(3);
        din_a = 8'h01; q0.push_back(4'b0010); tick(5);
        din_a = 8'h00; q0.push_back(4'b0000); tick(5);

        // Debounce: 8-clk glitch spans two ticks, 12-clk hold spans three.
        din_b = 8'h01; tick(8);
        din_b = 8'h00; tick(20);
        check("db_glitch", dout_b[3:0], 4'b0000);
        din_b = 8'h01; q2.push_back(4'b0001); tick(12);
        din_b = 8'h00; q2.push_back(4'b0000); tick(30);
        check("db_final", dout_b[3:0], 4'b0000);

        tick(10);
        n_vec++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d/%0d transitions outstanding, expected 0/0/0",
                     q0.size(), q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
